// File: rtl/store_monitor.sv
// store_monitor: watches CPU stores for a success pattern, flags a cycle
// budget timeout, and optionally records every store in a first-word-fall-
// through trace FIFO.
// Optional feature macro: STORE_MONITOR_TRACE_EN (trace FIFO present when defined).
//
// Trace handshake: trace_valid=1 means the head fields are valid; asserting
// rd_en while trace_valid=1 consumes the head on the next rising edge. rd_en
// while trace_valid=0 is ignored. There is no backpressure on the store side:
// a store arriving while the FIFO is full and not being popped is dropped and
// recorded in the sticky overflow flag.
module store_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [63:0] PASS_DATA = 64'd7,
    parameter logic [63:0] PASS_ADR0 = 64'd84,
    parameter logic [63:0] PASS_ADR1 = 64'd128,
    parameter int          TIMEOUT   = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  memwrite,
    input  logic [63:0] dataadr,
    input  logic [63:0] writedata,
    input  logic        rd_en,
    output logic        trace_valid,
    output logic [63:0] trace_adr,
    output logic [63:0] trace_data,
    output logic [1:0]  trace_kind,
    output logic [4:0]  trace_count,
    output logic        overflow,
    output logic        pass,
    output logic        timeout,
    output logic [9:0]  cycles
);

    localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);
    localparam logic [4:0] DEPTH_C   = 5'(DEPTH);
    localparam logic [9:0] CYC_MAX   = 10'd1023;

    logic       halted;
    logic       store_ev;
    logic       match;
    logic [9:0] cycles_nxt;

    // Decode the current edge: store event, success match and next cycle count.
    always_comb begin
        halted     = pass | timeout;
        store_ev   = (memwrite != 2'b00) && !halted;
        match      = store_ev && (writedata == PASS_DATA) &&
                     ((dataadr == PASS_ADR0) || (dataadr == PASS_ADR1));
        cycles_nxt = (cycles == CYC_MAX) ? cycles : cycles + 10'd1;
    end

    // Status: cycle counter and sticky pass/timeout; a match beats a timeout on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles  <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else if (!halted) begin
            cycles <= cycles_nxt;
            if (match)
                pass <= 1'b1;
            else if (cycles_nxt == TIMEOUT_C)
                timeout <= 1'b1;
        end
    end

`ifdef STORE_MONITOR_TRACE_EN
    localparam int AW = $clog2(DEPTH);

    logic [129:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [4:0]    count;
    logic          full;
    logic          pop;
    logic          do_push;

    // FIFO control: a pop frees a slot on the same edge, so push+pop is legal when full.
    always_comb begin
        full    = (count == DEPTH_C);
        pop     = rd_en && (count != 5'd0);
        do_push = store_ev && (!full || pop);
    end

    // FIFO pointers, occupancy and sticky overflow; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + 5'(do_push) - 5'(pop);
            if (store_ev && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Trace storage: not reset, entries are only read while marked valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= {dataadr, writedata, memwrite};
    end

    // Head presentation: fall-through from storage, forced to zero when empty.
    always_comb begin
        trace_valid = (count != 5'd0);
        trace_count = count;
        {trace_adr, trace_data, trace_kind} = trace_valid ? mem[rptr] : 130'd0;
    end
`else
    logic unused_trace;

    // Trace disabled: all trace outputs held at zero, rd_en has no effect.
    always_comb begin
        trace_valid  = 1'b0;
        trace_adr    = '0;
        trace_data   = '0;
        trace_kind   = '0;
        trace_count  = '0;
        overflow     = 1'b0;
        unused_trace = &{1'b0, rd_en, DEPTH_C};
    end
`endif

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: directed stores with hand-computed expectations.
// Trace entries expected to be read are queued at issue time; a negedge
// monitor compares each popped head against the queue.
module tb_store_monitor;

`ifdef STORE_MONITOR_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  memwrite;
    logic [63:0] dataadr;
    logic [63:0] writedata;
    logic        rd_en;
    logic        trace_valid;
    logic [63:0] trace_adr;
    logic [63:0] trace_data;
    logic [1:0]  trace_kind;
    logic [4:0]  trace_count;
    logic        overflow;
    logic        pass;
    logic        timeout;
    logic [9:0]  cycles;

    logic [129:0] exp_q[$];
    int checks;
    int failures;

    store_monitor dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .rd_en(rd_en), .trace_valid(trace_valid),
        .trace_adr(trace_adr), .trace_data(trace_data), .trace_kind(trace_kind),
        .trace_count(trace_count), .overflow(overflow), .pass(pass),
        .timeout(timeout), .cycles(cycles)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One store, optionally with a pop on the same edge; q=1 queues it as expected trace content.
    task automatic store(input logic [63:0] adr, input logic [63:0] data,
                         input logic [1:0] kind, input bit pop, input bit q);
        memwrite  = kind;
        dataadr   = adr;
        writedata = data;
        rd_en     = pop;
        if (q && TRACE) exp_q.push_back({adr, data, kind});
        step();
        memwrite  = 2'b00;
        dataadr   = '0;
        writedata = '0;
        rd_en     = 1'b0;
    endtask

    task automatic pops(input int n);
        rd_en = 1'b1;
        idle(n);
        rd_en = 1'b0;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear immediately.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, "_rst_pass"}, 64'(pass), 64'd0);
        check({tag, "_rst_cycles"}, 64'(cycles), 64'd0);
        check({tag, "_rst_count"}, 64'(trace_count), 64'd0);
        check({tag, "_rst_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_rst_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_rst_valid"}, 64'(trace_valid), 64'd0);
        exp_q.delete();
        #2 reset = 1'b1;
    endtask

    function automatic logic [63:0] sadr(input int i);
        return 64'h1000 + 64'(i) * 64'd8;
    endfunction

    // Scoreboard monitor: compare each consumed head against the expected queue.
    always @(negedge clk) begin
        if (reset && rd_en && trace_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL trace_pop unexpected entry adr=%0h data=%0h", trace_adr, trace_data);
            end else begin
                logic [129:0] e;
                e = exp_q.pop_front();
                if ({trace_adr, trace_data, trace_kind} !== e) begin
                    failures++;
                    $display("FAIL trace_pop actual=%0h expected=%0h",
                             {trace_adr, trace_data, trace_kind}, e);
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        memwrite = 2'b00;
        dataadr = '0;
        writedata = '0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("init_pass", 64'(pass), 64'd0);
        check("init_cycles", 64'(cycles), 64'd0);
        check("init_valid", 64'(trace_valid), 64'd0);
        check("init_count", 64'(trace_count), 64'd0);
        reset = 1'b1;

        // Success store on the 30th edge.
        idle(29);
        check("t1_cycles29", 64'(cycles), 64'd29);
        check("t1_pass_pre", 64'(pass), 64'd0);
        store(64'd84, 64'd7, 2'b01, 1'b0, 1'b1);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_cycles", 64'(cycles), 64'd30);
        check("t1_count", 64'(trace_count), TRACE ? 64'd1 : 64'd0);
        check("t1_head_adr", trace_adr, TRACE ? 64'd84 : 64'd0);
        store(64'd84, 64'd7, 2'b01, 1'b0, 1'b0);
        idle(3);
        check("t1_frozen", 64'(cycles), 64'd30);
        check("t1_timeout", 64'(timeout), 64'd0);
        check("t1_count_halt", 64'(trace_count), TRACE ? 64'd1 : 64'd0);
        pops(1);
        check("t1_drained", 64'(trace_valid), 64'd0);
        check("t1_empty_adr", trace_adr, 64'd0);

        // Mid-cycle reset after pass, counting resumes.
        pulse_reset("t7");
        step();
        check("t7_cycle1", 64'(cycles), 64'd1);

        // Wrong data at 84 is traced but no pass; 128/7 passes.
        store(64'd84, 64'd6, 2'b10, 1'b0, 1'b1);
        check("t2_nopass", 64'(pass), 64'd0);
        store(64'd128, 64'd7, 2'b11, 1'b0, 1'b1);
        check("t2_pass", 64'(pass), 64'd1);
        check("t2_cycles", 64'(cycles), 64'd3);
        check("t2_count", 64'(trace_count), TRACE ? 64'd2 : 64'd0);
        pops(2);
        check("t2_count0", 64'(trace_count), 64'd0);

        // Timeout after 200 cycles, later success store ignored.
        pulse_reset("t3");
        idle(199);
        check("t3_cycles199", 64'(cycles), 64'd199);
        check("t3_to_pre", 64'(timeout), 64'd0);
        step();
        check("t3_timeout", 64'(timeout), 64'd1);
        check("t3_cycles", 64'(cycles), 64'd200);
        store(64'd84, 64'd7, 2'b01, 1'b0, 1'b0);
        check("t3_nopass", 64'(pass), 64'd0);
        check("t3_count", 64'(trace_count), 64'd0);
        check("t3_frozen", 64'(cycles), 64'd200);

        // Match on the timeout edge: pass wins.
        pulse_reset("t4");
        idle(199);
        store(64'd128, 64'd7, 2'b01, 1'b0, 1'b1);
        check("t4_pass", 64'(pass), 64'd1);
        check("t4_timeout", 64'(timeout), 64'd0);
        check("t4_cycles", 64'(cycles), 64'd200);
        pops(1);

        // Nine stores into eight entries, then drain.
        pulse_reset("t5");
        for (int i = 1; i <= 9; i++)
            store(sadr(i), 64'hA0 + 64'(i), 2'((i % 3) + 1), 1'b0, i <= 8);
        check("t5_count", 64'(trace_count), TRACE ? 64'd8 : 64'd0);
        check("t5_overflow", 64'(overflow), TRACE ? 64'd1 : 64'd0);
        check("t5_head", trace_adr, TRACE ? sadr(1) : 64'd0);
        pops(8);
        check("t5_valid", 64'(trace_valid), 64'd0);
        check("t5_qempty", 64'(exp_q.size()), 64'd0);

        // Full FIFO with push and pop on the same edge.
        pulse_reset("t6");
        for (int i = 1; i <= 8; i++)
            store(sadr(i), 64'hA0 + 64'(i), 2'b01, 1'b0, 1'b1);
        store(sadr(9), 64'hA9, 2'b10, 1'b1, 1'b1);
        check("t6_count", 64'(trace_count), TRACE ? 64'd8 : 64'd0);
        check("t6_overflow", 64'(overflow), 64'd0);
        check("t6_head", trace_adr, TRACE ? sadr(2) : 64'd0);
        pops(8);
        check("t6_valid", 64'(trace_valid), 64'd0);
        pops(2);
        check("t6_empty_pop", 64'(trace_count), 64'd0);
        check("t6_qempty", 64'(exp_q.size()), 64'd0);
        check("t6_nopass", 64'(pass), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
